// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide unit: default operand
// width, iteration count and the sequencer state encoding.
package cpu_pkg;

  localparam int MDU_WIDTH      = 32;
  localparam int MDU_ITERATIONS = MDU_WIDTH;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MULT = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, so a
// full divide takes WIDTH steps after the load.
module mdu_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Partial remainder stays below the divisor, so one extra bit is enough
  // to hold the shifted trial value and the sign of the trial subtraction.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide unit: WIDTH iterations
// followed by a sign-fix cycle that loads HI/LO and pulses Done.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start_Mult,
  input  logic             Start_Div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t state, next_state;

  logic [CNT_W-1:0] count;
  logic             count_last;
  logic             accept_mult, accept_div, div_zero_hit;
  logic             mult_step, div_step, finish;

  logic             op_div;
  logic             quo_neg, rem_neg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   booth_hi;
  logic [WIDTH-1:0] booth_lo;
  logic             booth_qm1;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mcand_ext;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH-1:0] quo_fixed, rem_fixed;

  assign count_last = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clock) begin
    if (Reset) state <= MDU_IDLE;
    else       state <= next_state;
  end

  // Only IDLE samples the start strobes; multiply wins a simultaneous request
  // and a zero divisor is rejected without leaving IDLE.
  always_comb begin
    next_state   = state;
    accept_mult  = 1'b0;
    accept_div   = 1'b0;
    div_zero_hit = 1'b0;
    mult_step    = 1'b0;
    div_step     = 1'b0;
    finish       = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (Start_Mult) begin
          accept_mult = 1'b1;
          next_state  = MDU_MULT;
        end else if (Start_Div) begin
          if (B == '0) begin
            div_zero_hit = 1'b1;
          end else begin
            accept_div = 1'b1;
            next_state = MDU_DIV;
          end
        end
      end
      MDU_MULT: begin
        mult_step = 1'b1;
        if (count_last) next_state = MDU_FIX;
      end
      MDU_DIV: begin
        div_step = 1'b1;
        if (count_last) next_state = MDU_FIX;
      end
      MDU_FIX: begin
        finish     = 1'b1;
        next_state = MDU_IDLE;
      end
      default: next_state = MDU_IDLE;
    endcase
  end

  // Booth step: add/subtract the multiplicand into the widened upper half,
  // then arithmetic-shift the whole {upper, lower, q-1} chain right by one.
  always_comb begin
    mcand_ext = {mcand[WIDTH-1], mcand};
    booth_sum = booth_hi;
    case ({booth_lo[0], booth_qm1})
      2'b01:   booth_sum = booth_hi + mcand_ext;
      2'b10:   booth_sum = booth_hi - mcand_ext;
      default: booth_sum = booth_hi;
    endcase
  end

  always_comb begin
    a_mag     = A[WIDTH-1] ? ('0 - A) : A;
    b_mag     = B[WIDTH-1] ? ('0 - B) : B;
    quo_fixed = quo_neg ? ('0 - div_quo) : div_quo;
    rem_fixed = rem_neg ? ('0 - div_rem) : div_rem;
  end

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (accept_div),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count     <= '0;
      op_div    <= 1'b0;
      quo_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      mcand     <= '0;
      booth_hi  <= '0;
      booth_lo  <= '0;
      booth_qm1 <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
      Div_Zero  <= 1'b0;
    end else begin
      Done     <= finish;
      Div_Zero <= div_zero_hit;
      if (accept_mult || accept_div) begin
        count     <= '0;
        op_div    <= accept_div;
        quo_neg   <= A[WIDTH-1] ^ B[WIDTH-1];
        rem_neg   <= A[WIDTH-1];
        mcand     <= A;
        booth_hi  <= '0;
        booth_lo  <= B;
        booth_qm1 <= 1'b0;
      end else if (mult_step || div_step) begin
        count <= count + 1'b1;
      end
      if (mult_step) begin
        booth_hi  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo  <= {booth_sum[0], booth_lo[WIDTH-1:1]};
        booth_qm1 <= booth_lo[0];
      end
      if (finish) begin
        if (op_div) begin
          HI <= rem_fixed;
          LO <= quo_fixed;
        end else begin
          HI <= booth_hi[WIDTH-1:0];
          LO <= booth_lo;
        end
      end
    end
  end

  assign Busy = (state != MDU_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// back-to-back operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start_Mult = 1'b0;
  logic        Start_Div = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic        Busy, Done, Div_Zero;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start_Mult (Start_Mult),
    .Start_Div  (Start_Div),
    .A          (A),
    .B          (B),
    .HI         (HI),
    .LO         (LO),
    .Busy       (Busy),
    .Done       (Done),
    .Div_Zero   (Div_Zero)
  );

  always #5 Clock = ~Clock;

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Returns {remainder, quotient}; SV division truncates toward zero and the
  // remainder takes the dividend's sign, which is exactly the required rule.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 64'(sa / sb);
    r = 64'(sa % sb);
    return {r[31:0], q[31:0]};
  endfunction

  // Issues a start at the current negedge and waits for Done; returns at the
  // negedge where Done is observed so a caller may start again back-to-back.
  task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output bit got_done, output bit busy_at_done);
    Start_Mult = sm;
    Start_Div  = sd;
    A = a;
    B = b;
    @(negedge Clock);
    Start_Mult = 1'b0;
    Start_Div  = 1'b0;
    A = $urandom;
    B = $urandom;
    busy_cnt = 0;
    got_done = 1'b0;
    busy_at_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        got_done = 1'b1;
        busy_at_done = Busy;
        break;
      end
      if (Busy) busy_cnt++;
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    n_cmp += 5;
    if (HI !== 32'h0)    begin n_err++; $display("[TB] FAIL reset_hi got=%h exp=0", HI); end
    if (LO !== 32'h0)    begin n_err++; $display("[TB] FAIL reset_lo got=%h exp=0", LO); end
    if (Busy !== 1'b0)   begin n_err++; $display("[TB] FAIL reset_busy got=%b exp=0", Busy); end
    if (Done !== 1'b0)   begin n_err++; $display("[TB] FAIL reset_done got=%b exp=0", Done); end
    if (Div_Zero !== 1'b0) begin n_err++; $display("[TB] FAIL reset_divzero got=%b exp=0", Div_Zero); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_directed_mult();
    int bc; bit gd, bd;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, bc, gd, bd);
    n_cmp += 5;
    if (!gd)            begin n_err++; $display("[TB] FAIL mult7_done_timeout got=0 exp=1"); end
    if (bc !== 33)      begin n_err++; $display("[TB] FAIL mult7_busy_cycles got=%0d exp=33", bc); end
    if (bd !== 1'b0)    begin n_err++; $display("[TB] FAIL mult7_busy_at_done got=%b exp=0", bd); end
    if (HI !== 32'hFFFFFFFF) begin n_err++; $display("[TB] FAIL mult7_hi got=%h exp=ffffffff", HI); end
    if (LO !== 32'hFFFFFFEB) begin n_err++; $display("[TB] FAIL mult7_lo got=%h exp=ffffffeb", LO); end
    @(negedge Clock);
    n_cmp++;
    if (Done !== 1'b0) begin n_err++; $display("[TB] FAIL done_one_cycle got=%b exp=0", Done); end
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, bc, gd, bd);
    n_cmp += 3;
    if (!gd)                 begin n_err++; $display("[TB] FAIL multmin_done_timeout got=0 exp=1"); end
    if (HI !== 32'h40000000) begin n_err++; $display("[TB] FAIL multmin_hi got=%h exp=40000000", HI); end
    if (LO !== 32'h00000000) begin n_err++; $display("[TB] FAIL multmin_lo got=%h exp=00000000", LO); end
    @(negedge Clock);
  endtask

  task automatic test_directed_div();
    int bc; bit gd, bd;
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, bc, gd, bd);
    n_cmp += 4;
    if (!gd)                 begin n_err++; $display("[TB] FAIL divneg_done_timeout got=0 exp=1"); end
    if (bc !== 33)           begin n_err++; $display("[TB] FAIL divneg_busy_cycles got=%0d exp=33", bc); end
    if (LO !== 32'hFFFFFFFD) begin n_err++; $display("[TB] FAIL divneg_lo got=%h exp=fffffffd", LO); end
    if (HI !== 32'hFFFFFFFF) begin n_err++; $display("[TB] FAIL divneg_hi got=%h exp=ffffffff", HI); end
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, bc, gd, bd);
    n_cmp += 3;
    if (!gd)                 begin n_err++; $display("[TB] FAIL divwrap_done_timeout got=0 exp=1"); end
    if (LO !== 32'h80000000) begin n_err++; $display("[TB] FAIL divwrap_lo got=%h exp=80000000", LO); end
    if (HI !== 32'h00000000) begin n_err++; $display("[TB] FAIL divwrap_hi got=%h exp=0", HI); end
    @(negedge Clock);
  endtask

  task automatic test_div_zero();
    logic [31:0] old_hi, old_lo;
    old_hi = 32'h00000000;
    old_lo = 32'h80000000;
    Start_Div = 1'b1;
    A = 32'd1234;
    B = 32'd0;
    @(negedge Clock);
    Start_Div = 1'b0;
    n_cmp += 5;
    if (Div_Zero !== 1'b1) begin n_err++; $display("[TB] FAIL divzero_pulse got=%b exp=1", Div_Zero); end
    if (Busy !== 1'b0)     begin n_err++; $display("[TB] FAIL divzero_busy got=%b exp=0", Busy); end
    if (Done !== 1'b0)     begin n_err++; $display("[TB] FAIL divzero_done got=%b exp=0", Done); end
    if (HI !== old_hi)     begin n_err++; $display("[TB] FAIL divzero_hi got=%h exp=%h", HI, old_hi); end
    if (LO !== old_lo)     begin n_err++; $display("[TB] FAIL divzero_lo got=%h exp=%h", LO, old_lo); end
    @(negedge Clock);
    n_cmp += 3;
    if (Div_Zero !== 1'b0) begin n_err++; $display("[TB] FAIL divzero_width got=%b exp=0", Div_Zero); end
    if (Busy !== 1'b0)     begin n_err++; $display("[TB] FAIL divzero_busy2 got=%b exp=0", Busy); end
    if (Done !== 1'b0)     begin n_err++; $display("[TB] FAIL divzero_done2 got=%b exp=0", Done); end
  endtask

  task automatic test_reset_abort();
    int bc; bit gd, bd, saw_done;
    Start_Mult = 1'b1;
    A = 32'h12345678;
    B = 32'h0000FFFF;
    @(negedge Clock);
    Start_Mult = 1'b0;
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    Start_Div = 1'b1;
    A = 32'd50;
    B = 32'd5;
    @(negedge Clock);
    Reset = 1'b0;
    Start_Div = 1'b0;
    n_cmp += 4;
    if (HI !== 32'h0)  begin n_err++; $display("[TB] FAIL abort_hi got=%h exp=0", HI); end
    if (LO !== 32'h0)  begin n_err++; $display("[TB] FAIL abort_lo got=%h exp=0", LO); end
    if (Busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy got=%b exp=0", Busy); end
    if (Done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_done got=%b exp=0", Done); end
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (Done || Busy) saw_done = 1'b1;
      @(negedge Clock);
    end
    n_cmp++;
    if (saw_done) begin n_err++; $display("[TB] FAIL abort_activity got=1 exp=0"); end
    run_op(1'b0, 1'b1, 32'd100, 32'd7, bc, gd, bd);
    n_cmp += 3;
    if (!gd)          begin n_err++; $display("[TB] FAIL div100_done_timeout got=0 exp=1"); end
    if (LO !== 32'd14) begin n_err++; $display("[TB] FAIL div100_lo got=%0d exp=14", LO); end
    if (HI !== 32'd2)  begin n_err++; $display("[TB] FAIL div100_hi got=%0d exp=2", HI); end
    @(negedge Clock);
  endtask

  task automatic test_both_starts();
    int bc; bit gd;
    Start_Mult = 1'b1;
    Start_Div  = 1'b1;
    A = 32'd5;
    B = 32'd9;
    @(negedge Clock);
    Start_Mult = 1'b0;
    Start_Div  = 1'b0;
    bc = 0;
    gd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin gd = 1'b1; break; end
      if (Busy) bc++;
      Start_Div = (i == 4);
      A = (i == 4) ? 32'd100 : 32'd5;
      B = (i == 4) ? 32'd3 : 32'd9;
      @(negedge Clock);
    end
    Start_Div = 1'b0;
    n_cmp += 4;
    if (!gd)          begin n_err++; $display("[TB] FAIL both_done_timeout got=0 exp=1"); end
    if (bc !== 33)    begin n_err++; $display("[TB] FAIL both_busy_cycles got=%0d exp=33", bc); end
    if (HI !== 32'd0) begin n_err++; $display("[TB] FAIL both_hi got=%h exp=0", HI); end
    if (LO !== 32'd45) begin n_err++; $display("[TB] FAIL both_lo got=%0d exp=45", LO); end
    @(negedge Clock);
    n_cmp += 2;
    if (Busy !== 1'b0) begin n_err++; $display("[TB] FAIL both_no_queue_busy got=%b exp=0", Busy); end
    if (Done !== 1'b0) begin n_err++; $display("[TB] FAIL both_no_queue_done got=%b exp=0", Done); end
  endtask

  task automatic test_back_to_back();
    int bc; bit gd, bd, is_mult;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic [31:0] corner [4];
    corner[0] = 32'h80000000;
    corner[1] = 32'hFFFFFFFF;
    corner[2] = 32'h7FFFFFFF;
    corner[3] = 32'h00000001;
    for (int n = 0; n < 24; n++) begin
      is_mult = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      if (!is_mult && ($urandom_range(0, 2) == 0)) b = 32'($urandom_range(1, 300));
      if (!is_mult && b == 32'd0) b = 32'd3;
      exp = is_mult ? ref_mult(a, b) : ref_div(a, b);
      run_op(is_mult, !is_mult, a, b, bc, gd, bd);
      n_cmp += 5;
      if (!gd)         begin n_err++; $display("[TB] FAIL b2b_done_timeout op=%0d got=0 exp=1", n); end
      if (bc !== 33)   begin n_err++; $display("[TB] FAIL b2b_busy_cycles op=%0d got=%0d exp=33", n, bc); end
      if (bd !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_busy_at_done op=%0d got=%b exp=0", n, bd); end
      if (HI !== exp[63:32]) begin
        n_err++;
        $display("[TB] FAIL b2b_hi op=%0d mult=%0b a=%h b=%h got=%h exp=%h", n, is_mult, a, b, HI, exp[63:32]);
      end
      if (LO !== exp[31:0]) begin
        n_err++;
        $display("[TB] FAIL b2b_lo op=%0d mult=%0b a=%h b=%h got=%h exp=%h", n, is_mult, a, b, LO, exp[31:0]);
      end
      if (n % 6 == 5) begin
        @(negedge Clock);
        n_cmp += 3;
        if (Done !== 1'b0)     begin n_err++; $display("[TB] FAIL b2b_gap_done got=%b exp=0", Done); end
        if (HI !== exp[63:32]) begin n_err++; $display("[TB] FAIL b2b_hold_hi got=%h exp=%h", HI, exp[63:32]); end
        if (LO !== exp[31:0])  begin n_err++; $display("[TB] FAIL b2b_hold_lo got=%h exp=%h", LO, exp[31:0]); end
      end
    end
    @(negedge Clock);
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_directed_mult();
    test_directed_div();
    test_div_zero();
    test_reset_abort();
    test_both_starts();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: Clock  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Start_Mult  input  1  one-cycle request from the control unit to start a signed multiply.
REQ-004 SHALL have port: Start_Div  input  1  one-cycle request from the control unit to start a signed divide.
REQ-005 SHALL have port: A  input  32  multiplicand or dividend (register A contents).
REQ-006 SHALL have port: B  input  32  multiplier or divisor (register B contents).
REQ-007 SHALL have port: HI  output  32  product upper word, or remainder.
REQ-008 SHALL have port: LO  output  32  product lower word, or quotient.
REQ-009 SHALL have port: Busy  output  1  operation in progress.
REQ-010 SHALL have port: Done  output  1  one-cycle pulse: HI/LO just updated.
REQ-011 SHALL have port: Div_Zero  output  1  one-cycle pulse to the exception control unit.
REQ-012 SHALL have parameter: WIDTH, default 32, meaning operand width; iteration count equals WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, MULT, DIV, FIX; IDLE is the only state that accepts a start.
REQ-014 SHALL sample starts only in IDLE: Start_Mult -> MULT; Start_Div with B!=0 -> DIV; Start_Div with B==0 -> stay IDLE.
REQ-015 SHALL give Start_Mult priority when both starts are high in the same cycle.
REQ-016 SHALL ignore starts while Busy=1; no queuing.
REQ-017 SHALL latch A and B on the accepting edge k; later changes to A or B SHALL NOT affect the result.
REQ-018 SHALL perform one iteration per edge on edges k+1..k+32: radix-2 Booth for multiply, restoring divide on magnitudes for divide.
REQ-019 SHALL move to FIX after edge k+32; FIX SHALL apply sign correction and load HI/LO on edge k+33.
REQ-020 SHALL drive Busy=1 from after edge k until edge k+33; Busy SHALL be 0 when Done rises.
REQ-021 SHALL drive Done=1 for exactly the one cycle following edge k+33, then return to IDLE.
REQ-022 multiply result SHALL be {HI,LO} = full 64-bit two's-complement product of A and B.
REQ-023 divide result SHALL be LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-024 divide of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wraps, no exception).
REQ-025 divide by zero SHALL pulse Div_Zero for the one cycle after the accepting edge, leave HI/LO unchanged, keep Busy=0, and keep Done=0.
REQ-026 HI/LO SHALL hold their values between operations and SHALL change only at the FIX edge or on reset.
REQ-027 a start in the Done cycle SHALL be accepted, giving back-to-back operations.

Reset
REQ-028 Reset SHALL force IDLE and HI=0, LO=0, Busy=0, Done=0, Div_Zero=0 on the next edge, including mid-operation.
REQ-029 an aborted operation SHALL produce no Done and no write to HI/LO; Reset SHALL override any start in the same cycle.

Structure
REQ-030 the FSM state encodings and the WIDTH/iteration-count constants SHALL live in the shared cpu package.
REQ-031 the divide datapath SHALL be the sub-module mdu_divider; the Booth step, counter, and FSM SHALL stay in mult_div_unit.

Verification
REQ-032 Mult A=7, B=0xFFFFFFFD -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done on cycle k+33, Busy high for 33 cycles.
REQ-033 Mult A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-034 Div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then Div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 Div with B=0 after a prior result -> Div_Zero pulses one cycle, HI/LO unchanged, Busy and Done stay 0.
REQ-036 Reset asserted on iteration 10 of a multiply -> HI=LO=0 and no Done; a new Start_Div 100/7 then gives LO=14, HI=2.
REQ-037 Start_Mult and Start_Div together, then a start mid-operation -> multiply runs alone; the second start is ignored.
